// File: rtl/gsc_pkg.sv
// Shared types and helpers for the gate statistics collector.
//   gsc_rec_t   : one summary record (counter fields sized for the widest
//                 supported CNT_W; the top zero-extends into them)
//   rec_state_e : record holding register state
//   popcount4() : number of set bits in a 4-bit vector
// Optional-feature macro used by the top: GSC_CHECK_EN
package gsc_pkg;

    localparam int WINDOW_ID_W = 8;
    // Widest CNT_W the record struct can hold.
    localparam int CNT_W_MAX   = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rec_state_e;

    typedef struct packed {
        logic [CNT_W_MAX-1:0]   both_cnt;
        logic [CNT_W_MAX-1:0]   any_cnt;
        logic [CNT_W_MAX+1:0]   diff_sum;
        logic [WINDOW_ID_W-1:0] window_id;
    } gsc_rec_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/gsc_sat_counter.sv
// Saturating accumulator.
//   clk, reset : clock, synchronous active-high reset
//   clr        : zero the accumulator next cycle (wins over en)
//   en         : add inc this cycle
//   inc        : increment amount
//   sum_sat    : current value plus inc, saturated at all-ones; this is the
//                value the accumulator takes when en=1, and lets the parent
//                capture a total that includes the current sample.
module gsc_sat_counter #(
    parameter int W     = 8,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     sum_sat
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W:0]   sum_wide;

    // One extra bit catches the carry out; inc never exceeds 2^W so a
    // single carry bit is enough to detect overflow.
    assign sum_wide = {1'b0, count_q} + (W+1)'(inc);
    assign sum_sat  = sum_wide[W] ? '1 : sum_wide[W-1:0];

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = sum_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/gates_stat_collector.sv
// Gate statistics collector.
// Samples the neighbour-gate vectors (out_both/out_any/out_different),
// accumulates per-window activity counts and emits one record per window
// through a single-entry valid/ready holding register.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   in_valid                : gate vectors valid this cycle
//   out_both/out_any/out_different : 4-bit gate vectors
//   clear                   : sync clear of statistics, window id and flags
//   rec_valid / rec_ready   : record handshake
//   rec_both_cnt, rec_any_cnt, rec_diff_sum, rec_window_id : record fields
//   overrun                 : sticky, a record was dropped
//   check_err               : sticky sample consistency error
// Optional feature: define GSC_CHECK_EN to enable the per-sample
// consistency check; otherwise check_err is tied to 0.
module gates_stat_collector
    import gsc_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [3:0]             out_both,
    input  logic [3:0]             out_any,
    input  logic [3:0]             out_different,
    input  logic                   clear,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [CNT_W-1:0]       rec_both_cnt,
    output logic [CNT_W-1:0]       rec_any_cnt,
    output logic [CNT_W+1:0]       rec_diff_sum,
    output logic [WINDOW_ID_W-1:0] rec_window_id,
    output logic                   overrun,
    output logic                   check_err
);

    localparam int SC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic                   accept;
    logic                   close;
    logic                   acc_clr;
    logic                   both_hit;
    logic                   any_hit;
    logic [2:0]             diff_pc;

    logic [CNT_W-1:0]       both_nxt;
    logic [CNT_W-1:0]       any_nxt;
    logic [CNT_W+1:0]       diff_nxt;

    logic [SC_W-1:0]        samp_q,      samp_d;
    logic [WINDOW_ID_W-1:0] window_id_q, window_id_d;
    rec_state_e             state_q,     state_d;
    gsc_rec_t               rec_q,       rec_d;
    logic                   overrun_q,   overrun_d;
    gsc_rec_t               rec_new;

    // A sample arriving together with clear is discarded.
    assign accept   = in_valid && !clear;
    assign close    = accept && (samp_q == SC_W'(WINDOW - 1));
    assign acc_clr  = clear || close;

    assign both_hit = |out_both[2:0];
    assign any_hit  = |out_any[3:1];
    assign diff_pc  = popcount4(out_different);

    gsc_sat_counter #(.W(CNT_W), .INC_W(1)) u_both_acc (
        .clk     (clk),
        .reset   (reset),
        .clr     (acc_clr),
        .en      (accept),
        .inc     (both_hit),
        .sum_sat (both_nxt)
    );

    gsc_sat_counter #(.W(CNT_W), .INC_W(1)) u_any_acc (
        .clk     (clk),
        .reset   (reset),
        .clr     (acc_clr),
        .en      (accept),
        .inc     (any_hit),
        .sum_sat (any_nxt)
    );

    gsc_sat_counter #(.W(CNT_W + 2), .INC_W(3)) u_diff_acc (
        .clk     (clk),
        .reset   (reset),
        .clr     (acc_clr),
        .en      (accept),
        .inc     (diff_pc),
        .sum_sat (diff_nxt)
    );

    // Record built from totals that already include the closing sample.
    always_comb begin
        rec_new           = '0;
        rec_new.both_cnt  = CNT_W_MAX'(both_nxt);
        rec_new.any_cnt   = CNT_W_MAX'(any_nxt);
        rec_new.diff_sum  = (CNT_W_MAX + 2)'(diff_nxt);
        rec_new.window_id = window_id_q;
    end

    always_comb begin
        samp_d      = samp_q;
        window_id_d = window_id_q;
        if (clear) begin
            samp_d      = '0;
            window_id_d = '0;
        end else if (close) begin
            samp_d      = '0;
            window_id_d = window_id_q + 1'b1;
        end else if (accept) begin
            samp_d      = samp_q + 1'b1;
        end
    end

    // Holding register: a close while the held record is not being taken
    // drops the new record; a close in the same cycle as a take reloads
    // without a bubble.
    always_comb begin
        state_d   = state_q;
        rec_d     = rec_q;
        overrun_d = overrun_q;
        unique case (state_q)
            EMPTY: begin
                if (close) begin
                    rec_d   = rec_new;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (close) begin
                    if (rec_ready) begin
                        rec_d = rec_new;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else if (rec_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        // close cannot coincide with clear, so this never hides a drop.
        if (clear) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            samp_q      <= '0;
            window_id_q <= '0;
            state_q     <= EMPTY;
            rec_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            samp_q      <= samp_d;
            window_id_q <= window_id_d;
            state_q     <= state_d;
            rec_q       <= rec_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef GSC_CHECK_EN
    logic check_err_q, check_err_d;
    logic sample_bad;

    // A both-bit implies the any-bit one position up; a ring XOR pattern
    // always has an even number of set bits.
    always_comb begin
        sample_bad  = (out_both[0] & ~out_any[1]) |
                      (out_both[1] & ~out_any[2]) |
                      (out_both[2] & ~out_any[3]) |
                      diff_pc[0];
        check_err_d = check_err_q;
        if (clear) begin
            check_err_d = 1'b0;
        end else if (accept && sample_bad) begin
            check_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            check_err_q <= 1'b0;
        end else begin
            check_err_q <= check_err_d;
        end
    end

    assign check_err = check_err_q;
`else
    assign check_err = 1'b0;
`endif

    assign rec_valid     = (state_q == FULL);
    assign rec_both_cnt  = rec_q.both_cnt[CNT_W-1:0];
    assign rec_any_cnt   = rec_q.any_cnt[CNT_W-1:0];
    assign rec_diff_sum  = rec_q.diff_sum[CNT_W+1:0];
    assign rec_window_id = rec_q.window_id;
    assign overrun       = overrun_q;

    // Gate bits that carry no information (out_both[3], out_any[0]) and
    // the always-zero upper record bits are intentionally not used.
    logic unused_bits;
    assign unused_bits = &{1'b0, out_both[3], out_any[0], rec_q};

endmodule

// File: tb/tb_gates_stat_collector.sv
module tb_gates_stat_collector;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] out_both = '0;
    logic [3:0] out_any = '0;
    logic [3:0] out_different = '0;
    logic       clear = 1'b0;
    logic       rec_ready = 1'b0;

    // dut A: WINDOW=4, CNT_W=8
    logic       a_rec_valid, a_overrun, a_check_err;
    logic [7:0] a_both, a_any, a_id;
    logic [9:0] a_diff;
    // dut B: WINDOW=16, CNT_W=3
    logic       b_rec_valid, b_overrun, b_check_err;
    logic [2:0] b_both, b_any;
    logic [4:0] b_diff;
    logic [7:0] b_id;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gates_stat_collector #(.WINDOW(4), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .out_both(out_both), .out_any(out_any), .out_different(out_different),
        .clear(clear), .rec_valid(a_rec_valid), .rec_ready(rec_ready),
        .rec_both_cnt(a_both), .rec_any_cnt(a_any), .rec_diff_sum(a_diff),
        .rec_window_id(a_id), .overrun(a_overrun), .check_err(a_check_err)
    );

    gates_stat_collector #(.WINDOW(16), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .out_both(out_both), .out_any(out_any), .out_different(out_different),
        .clear(clear), .rec_valid(b_rec_valid), .rec_ready(rec_ready),
        .rec_both_cnt(b_both), .rec_any_cnt(b_any), .rec_diff_sum(b_diff),
        .rec_window_id(b_id), .overrun(b_overrun), .check_err(b_check_err)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int win[2]  = '{4, 16};
    int cmax[2] = '{255, 7};
    int dmax[2] = '{1023, 31};

    // samples of the current window, kept per dut
    int s_both[2][16];
    int s_any[2][16];
    int s_diff[2][16];
    int n[2];
    int wid[2];
    int exp_valid[2], exp_both[2], exp_any[2], exp_diff[2], exp_id[2];
    int exp_ovr[2], exp_chk[2];

    function automatic int min_i(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    task automatic model_reset(input int d);
        n[d] = 0; wid[d] = 0;
        exp_valid[d] = 0; exp_both[d] = 0; exp_any[d] = 0; exp_diff[d] = 0;
        exp_id[d] = 0; exp_ovr[d] = 0; exp_chk[d] = 0;
    endtask

    task automatic model_step(input int d);
        bit consumed;
        bit closing;
        int tb_, ta_, td_;
        consumed = (exp_valid[d] != 0) && rec_ready;
        closing  = 1'b0;
        if (clear) begin
            n[d] = 0; wid[d] = 0; exp_ovr[d] = 0; exp_chk[d] = 0;
        end else if (in_valid) begin
            s_both[d][n[d]] = (out_both[2:0] != 3'b000) ? 1 : 0;
            s_any[d][n[d]]  = (out_any[3:1] != 3'b000) ? 1 : 0;
            s_diff[d][n[d]] = $countones(out_different);
            n[d]++;
`ifdef GSC_CHECK_EN
            if ((out_both[0] && !out_any[1]) || (out_both[1] && !out_any[2]) ||
                (out_both[2] && !out_any[3]) || ($countones(out_different) % 2 == 1))
                exp_chk[d] = 1;
`endif
            closing = (n[d] == win[d]);
        end
        if (closing) begin
            tb_ = 0; ta_ = 0; td_ = 0;
            for (int k = 0; k < win[d]; k++) begin
                tb_ += s_both[d][k]; ta_ += s_any[d][k]; td_ += s_diff[d][k];
            end
            if (exp_valid[d] != 0 && !consumed) begin
                exp_ovr[d] = 1;
            end else begin
                exp_valid[d] = 1;
                exp_both[d] = min_i(tb_, cmax[d]);
                exp_any[d]  = min_i(ta_, cmax[d]);
                exp_diff[d] = min_i(td_, dmax[d]);
                exp_id[d]   = wid[d];
            end
            wid[d] = (wid[d] + 1) % 256;
            n[d] = 0;
        end else if (consumed) begin
            exp_valid[d] = 0;
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) model_reset(d);
            else       model_step(d);
        end
    end

    task automatic cmp(input int d, input int v, input int ov, input int ce,
                       input int bc, input int ac, input int ds, input int id);
        check($sformatf("dut%0d.rec_valid", d), v, exp_valid[d]);
        check($sformatf("dut%0d.overrun", d), ov, exp_ovr[d]);
        check($sformatf("dut%0d.check_err", d), ce, exp_chk[d]);
        if (exp_valid[d] != 0) begin
            check($sformatf("dut%0d.both_cnt", d), bc, exp_both[d]);
            check($sformatf("dut%0d.any_cnt", d), ac, exp_any[d]);
            check($sformatf("dut%0d.diff_sum", d), ds, exp_diff[d]);
            check($sformatf("dut%0d.window_id", d), id, exp_id[d]);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            cmp(0, a_rec_valid, a_overrun, a_check_err, a_both, a_any, a_diff, a_id);
            cmp(1, b_rec_valid, b_overrun, b_check_err, b_both, b_any, b_diff, b_id);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic iv, input logic [3:0] b, input logic [3:0] a,
                       input logic [3:0] df, input logic clr);
        in_valid = iv; out_both = b; out_any = a; out_different = df; clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; clear = 1'b0; rec_ready = 1'b0;
        out_both = '0; out_any = '0; out_different = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int exp_chk_lit;

    initial begin
        @(posedge clk);
        #1;
        // 1: reset state
        do_reset();
        check("rst.a_valid", a_rec_valid, 0);
        check("rst.a_overrun", a_overrun, 0);
        check("rst.a_check_err", a_check_err, 0);
        check("rst.a_fields", int'(a_both) + int'(a_any) + int'(a_diff) + int'(a_id), 0);
        check("rst.b_valid", b_rec_valid, 0);
        check("rst.b_fields", int'(b_both) + int'(b_any) + int'(b_diff) + int'(b_id), 0);

        // 2: basic window
        rec_ready = 1'b1;
        repeat (3) cyc(1, 4'b0001, 4'b0010, 4'b0011, 0);
        check("t2.valid_before", a_rec_valid, 0);
        cyc(1, 4'b0001, 4'b0010, 4'b0011, 0);
        check("t2.valid", a_rec_valid, 1);
        check("t2.both", a_both, 4);
        check("t2.any", a_any, 4);
        check("t2.diff", a_diff, 8);
        check("t2.id", a_id, 0);

        // 3: overrun then recovery
        do_reset();
        rec_ready = 1'b0;
        repeat (8) cyc(1, 4'b0001, 4'b0010, 4'b0011, 0);
        check("t3.valid", a_rec_valid, 1);
        check("t3.held_id", a_id, 0);
        check("t3.overrun", a_overrun, 1);
        rec_ready = 1'b1;
        cyc(0, 4'b0000, 4'b0000, 4'b0000, 0);
        repeat (4) cyc(1, 4'b0001, 4'b0010, 4'b0011, 0);
        check("t3.next_valid", a_rec_valid, 1);
        check("t3.next_id", a_id, 2);

        // 4: saturation with CNT_W=3
        do_reset();
        rec_ready = 1'b1;
        repeat (16) cyc(1, 4'b0111, 4'b0000, 4'b0001, 0);
        check("t4.valid", b_rec_valid, 1);
        check("t4.both_sat", b_both, 7);
        check("t4.any", b_any, 0);
        check("t4.diff", b_diff, 16);

        // 5: idle cycles not counted
        do_reset();
        for (int k = 0; k < 7; k++) begin
            cyc((k % 2) == 0, 4'b0001, 4'b0010, 4'b0011, 0);
            if (k == 5) check("t5.valid_after3", a_rec_valid, 0);
        end
        check("t5.valid_after4", a_rec_valid, 1);
        check("t5.both", a_both, 4);

        // 6: clear while FULL mid-window
        do_reset();
        repeat (4) cyc(1, 4'b0000, 4'b0010, 4'b0011, 0);
        repeat (2) cyc(1, 4'b0001, 4'b0010, 4'b0011, 0);
        cyc(1, 4'b0001, 4'b0010, 4'b0011, 1);
        check("t6.valid_kept", a_rec_valid, 1);
        check("t6.held_both", a_both, 0);
        rec_ready = 1'b1;
        repeat (3) cyc(1, 4'b0001, 4'b0010, 4'b0011, 0);
        check("t6.valid_after3", a_rec_valid, 0);
        cyc(1, 4'b0001, 4'b0010, 4'b0011, 0);
        check("t6.valid_new", a_rec_valid, 1);
        check("t6.both_new", a_both, 4);
        check("t6.id_new", a_id, 0);

        // 7: consistency check
        do_reset();
        cyc(1, 4'b0001, 4'b0000, 4'b0000, 0);
`ifdef GSC_CHECK_EN
        exp_chk_lit = 1;
`else
        exp_chk_lit = 0;
`endif
        check("t7.a_check_err", a_check_err, exp_chk_lit);
        check("t7.b_check_err", b_check_err, exp_chk_lit);

        // random phase, checked every cycle by the model comparison
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rec_ready = ($urandom_range(0, 1) == 1);
            cyc($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 4'($urandom),
                $urandom_range(0, 49) == 0);
        end
        in_valid = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
